// File: rtl/fpmul_pkg.sv
// FP32 field layout, result-classification flag indices and the classifier
// shared by the multiplier result collector.
package fpmul_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    localparam int unsigned FLG_W      = 4;
    localparam int unsigned FLG_NAN    = 3;
    localparam int unsigned FLG_INF    = 2;
    localparam int unsigned FLG_ZERO   = 1;
    localparam int unsigned FLG_DENORM = 0;

    typedef logic [FLG_W-1:0] fp_flags_t;

    // One-hot class of an FP32 value; normal finite numbers map to all-zero.
    function automatic fp_flags_t fp_classify(input logic [FP_W-1:0] z);
        logic [EXP_W-1:0] w_exp;
        logic [MAN_W-1:0] w_man;
        fp_flags_t        w_flags;
        w_exp   = z[MAN_W +: EXP_W];
        w_man   = z[MAN_W-1:0];
        w_flags = '0;
        if (w_exp == EXP_MAX) begin
            if (w_man != '0) w_flags[FLG_NAN] = 1'b1;
            else             w_flags[FLG_INF] = 1'b1;
        end else if (w_exp == '0) begin
            if (w_man == '0) w_flags[FLG_ZERO]   = 1'b1;
            else             w_flags[FLG_DENORM] = 1'b1;
        end
        return w_flags;
    endfunction

endpackage

// File: rtl/fpmul_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; storage is cleared on
// reset so the head reads zero until the first write.
module fpmul_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd];

    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign w_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_push = i_push & (~o_full | w_pop) & ~i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fpmul_result_collector.sv
// Re-times operand valid by MUL_LAT, captures multiplier products into a FWFT
// FIFO and counts products lost to back-pressure. FPMUL_COLLECT_FLAGS_EN adds flags.
module fpmul_result_collector
    import fpmul_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          flush,
    input  logic [DATA_W-1:0]             mul_z,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
`ifdef FPMUL_COLLECT_FLAGS_EN
    output logic [3:0]                    out_flags,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic                          overflow
);

`ifdef FPMUL_COLLECT_FLAGS_EN
    localparam int unsigned ENT_W = DATA_W + FLG_W;
`else
    localparam int unsigned ENT_W = DATA_W;
`endif

    logic [MUL_LAT-1:0] r_vpipe;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic               r_overflow;

    logic               w_cap;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;
    logic [ENT_W-1:0]   w_wr_entry;
    logic [ENT_W-1:0]   w_rd_entry;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= in_valid;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    // cap marks the cycle in which mul_z holds a tracked product.
    assign w_cap  = r_vpipe[MUL_LAT-1];
    assign w_pop  = out_valid & out_ready;
    assign w_drop = w_cap & w_full & ~w_pop & ~flush;

`ifdef FPMUL_COLLECT_FLAGS_EN
    assign w_wr_entry = {fp_classify(mul_z), mul_z};
    assign out_flags  = w_rd_entry[DATA_W +: FLG_W];
`else
    assign w_wr_entry = mul_z;
`endif
    assign out_data  = w_rd_entry[DATA_W-1:0];
    assign out_valid = ~w_empty;

    fpmul_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_cap),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_data  (w_wr_entry),
        .o_data  (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // Drop accounting survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
            r_overflow <= 1'b1;
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign overflow = r_overflow;

endmodule
